avalon_mem_responder: RTL

Avalon-MM style memory responder: the target end of the CPU's instruction/data bus. It accepts one read or write at a time from the MIPS CPU initiator and stalls it with `waitrequest` for a programmable number of cycles. It applies byte-enabled writes to a word-addressed RAM mapped at the reset vector region. It is used in CPU testbenches and top-level simulation as the instruction and data memory.

---
 rtl/avalon_mem_responder_if.sv | 28 ++
 rtl/avalon_mem_responder.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/avalon_mem_responder_if.sv
// avalon_mem_responder_if
// Bundles the Avalon-MM style bus between the CPU initiator and the memory
// responder so both ends share one declaration.
//   address/read/write/byteenable/writedata : initiator -> responder
//   waitrequest/readdata                    : responder -> initiator
//   addr_error/protocol_error               : sticky diagnostic flags from the responder
// The master modport is the initiator (CPU or bench); slave is the memory.
interface avalon_mem_responder_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  byteenable;
    logic [31:0] writedata;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        addr_error;
    logic        protocol_error;

    modport master (
        output address, read, write, byteenable, writedata,
        input  waitrequest, readdata, addr_error, protocol_error
    );

    modport slave (
        input  address, read, write, byteenable, writedata,
        output waitrequest, readdata, addr_error, protocol_error
    );
endinterface

// File: rtl/avalon_mem_responder.sv
// avalon_mem_responder
// Target end of the CPU instruction/data bus. Accepts one read or write at a
// time, stalls the initiator with waitrequest for WAIT_CYCLES extra cycles,
// then performs the access on a word-addressed RAM mapped at ADDR_BASE.
// Ports:
//   clk   : single clock, everything changes on the rising edge
//   reset : synchronous, active-high; does not clear the RAM contents
//   bus   : slave side of avalon_mem_responder_if (request, data, waitrequest,
//           registered readdata, sticky addr_error / protocol_error)
module avalon_mem_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'hBFC00000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    avalon_mem_responder_if.slave bus
);

    localparam int          IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN      = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ACK
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;

    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic        lat_write;
    logic        lat_both;

    logic        req;
    logic        accept;
    logic        dropped;
    logic        do_access;
    logic        mem_we;
    logic [31:0] offset;
    logic        addr_ok;
    logic [IDX_W-1:0] idx;

    logic [31:0] mem [DEPTH_WORDS];

    // Address decode works on the latched address so late changes on the bus
    // cannot redirect a transfer. Subtracting first keeps the range test
    // correct even if ADDR_BASE + span would wrap past 32 bits.
    assign req     = bus.read | bus.write;
    assign offset  = lat_addr - ADDR_BASE;
    assign addr_ok = (lat_addr[1:0] == 2'b00) && (lat_addr >= ADDR_BASE) && (offset < SPAN);
    assign idx     = offset[IDX_W+1:2];

    // The RAM is only touched for a clean, in-range write; reset wins so a
    // write pending in BUSY is abandoned.
    assign mem_we = do_access & lat_write & ~lat_both & addr_ok & ~reset;

    // waitrequest stays high while a request is outstanding, except in the
    // ACK cycle where the transfer completes.
    assign bus.waitrequest = reset | (req & (state != ACK));

    // Next-state logic: IDLE accepts, BUSY counts down (or aborts if the
    // initiator lets go of the request), ACK always returns to IDLE.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        dropped    = 1'b0;
        do_access  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept     = 1'b1;
                    cnt_next   = WAIT_INIT;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (!req) begin
                    dropped    = 1'b1;
                    state_next = IDLE;
                end else if (cnt == 4'd0) begin
                    do_access  = 1'b1;
                    state_next = ACK;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            ACK: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register and wait countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Request latches, registered read data and the sticky error flags.
    // A request with both read and write high is flagged at acceptance and
    // then completes as a no-op that returns zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            lat_addr           <= 32'd0;
            lat_wdata          <= 32'd0;
            lat_be             <= 4'd0;
            lat_write          <= 1'b0;
            lat_both           <= 1'b0;
            bus.readdata       <= 32'd0;
            bus.addr_error     <= 1'b0;
            bus.protocol_error <= 1'b0;
        end else begin
            if (accept) begin
                lat_addr  <= bus.address;
                lat_wdata <= bus.writedata;
                lat_be    <= bus.byteenable;
                lat_write <= bus.write;
                lat_both  <= bus.read & bus.write;
                if (bus.read & bus.write) begin
                    bus.protocol_error <= 1'b1;
                end
            end
            if (dropped) begin
                bus.protocol_error <= 1'b1;
            end
            if (do_access) begin
                if (lat_both) begin
                    bus.readdata <= 32'd0;
                end else if (!addr_ok) begin
                    bus.addr_error <= 1'b1;
                    if (!lat_write) begin
                        bus.readdata <= 32'd0;
                    end
                end else if (!lat_write) begin
                    bus.readdata <= mem[idx];
                end
            end
        end
    end

    // RAM write port with per-byte lane enables; no reset so preloaded
    // programs survive a CPU reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (lat_be[i]) begin
                    mem[idx][8*i +: 8] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule
